// File: rtl/control_unit_seq.sv
// control_unit_seq -- D-stage decode and D->E control pipeline register for the RV32 core.
//
// Purpose:
//   Decodes op/funct3/funct7 combinationally in D and registers the control word into E.
//   The register supports stall, flush and bubble insertion. With CTRL_MULDIV_EN defined,
//   a small sequencer holds RV32M ops in E for MUL_CYCLES / DIV_CYCLES cycles. While it
//   does so it raises busy_o as a stall request to the hazard unit.
//
// Configuration macro:
//   CTRL_MULDIV_EN  defined   : RV32M decode plus the IDLE/BUSY sequencer.
//                   undefined : funct7=0000001 on OP is illegal; busy_o, MulDivE and MulDivOpE
//                               are tied 0 and no FSM/counter exists.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   instr_valid           D-stage instruction valid
//   op, funct3, funct7    instruction fields
//   stall_in, flush_in    hazard-unit hold / clear of the D/E register
//   ImmSrcD               combinational immediate select for the D-stage extend unit
//   *E outputs            registered E-stage control word
//   busy_o                multi-cycle mul/div stall request (Moore)

module control_unit_seq #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       stall_in,
    input  logic       flush_in,
    output logic [2:0] ImmSrcD,
    output logic       RegWriteE,
    output logic [1:0] ResultSrcE,
    output logic       MemWriteE,
    output logic       JumpE,
    output logic       BranchE,
    output logic [2:0] BranchCondE,
    output logic [3:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       ALUSrcAE,
    output logic       JALRInstrE,
    output logic [2:0] AddressingControlE,
    output logic       MulDivE,
    output logic [2:0] MulDivOpE,
    output logic       IllegalE,
    output logic       busy_o
);

    if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cfg
        $error("MUL_CYCLES and DIV_CYCLES must be at least 1");
    end

`ifdef CTRL_MULDIV_EN
    localparam bit MulDivOn = 1'b1;
`else
    localparam bit MulDivOn = 1'b0;
`endif

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] branch_cond;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       alu_src_a;
        logic       jalr;
        logic [2:0] addr_ctrl;
        logic       illegal;
    } ctrl_t;

    ctrl_t      w_dec;
    ctrl_t      w_next;
    ctrl_t      r_ctrl;
    logic [2:0] w_imm_src;
    logic       w_ill;
    logic       w_busy;
    logic       w_load;

    // Shared funct3 -> ALU code map for OP and OP-IMM; sra selects the arithmetic right shift.
    function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic sra);
        logic [3:0] code;
        code = 4'b0000;
        case (f3)
            3'b000:  code = 4'b0000;
            3'b001:  code = 4'b0111;
            3'b010:  code = 4'b0101;
            3'b011:  code = 4'b0110;
            3'b100:  code = 4'b0100;
            3'b101:  code = sra ? 4'b1011 : 4'b1000;
            3'b110:  code = 4'b0011;
            default: code = 4'b0010;
        endcase
        return code;
    endfunction

    always_comb begin
        w_dec     = '0;
        w_imm_src = 3'b000;
        w_ill     = 1'b0;
        case (op)
            7'b0110011: begin
                w_dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    w_dec.alu_control = alu_base(funct3, 1'b0);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      w_dec.alu_control = 4'b0001;
                    else if (funct3 == 3'b101) w_dec.alu_control = 4'b1011;
                    else                       w_ill = 1'b1;
                end else if (!(MulDivOn && funct7 == 7'b0000001)) begin
                    w_ill = 1'b1;
                end
            end
            7'b0010011: begin
                w_dec.reg_write   = 1'b1;
                w_dec.alu_src     = 1'b1;
                w_dec.alu_control = alu_base(funct3, funct7[5]);
            end
            7'b0000011: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b01;
                w_dec.alu_src    = 1'b1;
                w_dec.addr_ctrl  = funct3;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) w_ill = 1'b1;
            end
            7'b0100011: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.addr_ctrl = funct3;
                w_imm_src       = 3'b001;
                if (funct3 > 3'b010) w_ill = 1'b1;
            end
            7'b1100011: begin
                w_dec.branch      = 1'b1;
                w_dec.alu_control = 4'b0001;
                w_dec.branch_cond = funct3;
                w_imm_src         = 3'b010;
                if (funct3 == 3'b010 || funct3 == 3'b011) w_ill = 1'b1;
            end
            7'b1101111: begin
                w_dec.jump       = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_imm_src        = 3'b011;
            end
            7'b1100111: begin
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.alu_src    = 1'b1;
            end
            7'b0110111: begin
                w_dec.reg_write   = 1'b1;
                w_dec.alu_control = 4'b1111;
                w_dec.alu_src     = 1'b1;
                w_imm_src         = 3'b100;
            end
            7'b0010111: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_imm_src       = 3'b100;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal instructions travel as a bubble that only carries the illegal flag.
        if (w_ill) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
        if (!instr_valid) w_imm_src = 3'b000;
    end

    assign ImmSrcD = w_imm_src;
    assign w_next  = instr_valid ? w_dec : '0;
    assign w_load  = !flush_in && !w_busy && !stall_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else if (flush_in) begin
            r_ctrl <= '0;
        end else if (w_load) begin
            r_ctrl <= w_next;
        end
    end

`ifdef CTRL_MULDIV_EN
    localparam int unsigned MaxCyc = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MaxCyc + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_n_m1;
    logic             w_m_dec;
    logic             r_muldiv;
    logic [2:0]       r_muldiv_op;

    assign w_m_dec = instr_valid && (op == 7'b0110011) && (funct7 == 7'b0000001);
    assign w_n_m1  = funct3[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    assign w_busy  = (r_state == StBusy);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                // Single-cycle ops (N=1) never enter BUSY.
                if (w_load && w_m_dec && (w_n_m1 != '0)) begin
                    w_state_d = StBusy;
                    w_cnt_d   = w_n_m1;
                end
            end
            StBusy: begin
                w_cnt_d = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        if (flush_in) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_muldiv    <= 1'b0;
            r_muldiv_op <= 3'b000;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (flush_in) begin
                r_muldiv    <= 1'b0;
                r_muldiv_op <= 3'b000;
            end else if (w_load) begin
                r_muldiv    <= w_m_dec;
                r_muldiv_op <= w_m_dec ? funct3 : 3'b000;
            end
        end
    end

    assign MulDivE   = r_muldiv;
    assign MulDivOpE = r_muldiv_op;
`else
    assign w_busy    = 1'b0;
    assign MulDivE   = 1'b0;
    assign MulDivOpE = 3'b000;
`endif

    assign busy_o             = w_busy;
    assign RegWriteE          = r_ctrl.reg_write;
    assign ResultSrcE         = r_ctrl.result_src;
    assign MemWriteE          = r_ctrl.mem_write;
    assign JumpE              = r_ctrl.jump;
    assign BranchE            = r_ctrl.branch;
    assign BranchCondE        = r_ctrl.branch_cond;
    assign ALUControlE        = r_ctrl.alu_control;
    assign ALUSrcE            = r_ctrl.alu_src;
    assign ALUSrcAE           = r_ctrl.alu_src_a;
    assign JALRInstrE         = r_ctrl.jalr;
    assign AddressingControlE = r_ctrl.addr_ctrl;
    assign IllegalE           = r_ctrl.illegal;

endmodule
